lock_ctrl_p: RTL and testbench

Parametrised digital-lock controller: compares a user-entered code against a stored password, counts failed attempts, enforces a timed lockout after too many failures, auto-relocks after a timed open window, and allows the password to be changed while open. It sits between the keypad/code-assembly logic (which supplies `pw_in` and the `enb_cmp` strobe) and the lock actuator and status display (`enb_lock`, `gen_stop`, `error_counter`).

---
 rtl/lock_ctrl_p.sv | 157 +++++++++++++++
 tb/tb_lock_ctrl_p.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lock_ctrl_p.sv
// rtl/lock_ctrl_p.sv - code-compare lock controller with failure lockout, timed open window and password change
module lock_ctrl_p #(
  parameter int DIGITS      = 4,
  parameter logic [4*DIGITS-1:0] DEFAULT_PW = '0,
  parameter int MAX_ERR     = 3,
  parameter int LOCKOUT_CYC = 1000,
  parameter int OPEN_CYC    = 500,
  localparam int PW_W = 4*DIGITS,
  localparam int EW   = $clog2(MAX_ERR+1)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [PW_W-1:0] pw_in,
  input  logic            enb_cmp,
  input  logic            set_pw,
  input  logic            rst_out,
  output logic            enb_lock,
  output logic            gen_stop,
  output logic [EW-1:0]   error_counter,
  output logic            gen_rst,
  output logic            pw_changed
);

  localparam int T_MAX = (LOCKOUT_CYC > OPEN_CYC) ? LOCKOUT_CYC : OPEN_CYC;
  localparam int TW    = ($clog2(T_MAX) < 1) ? 1 : $clog2(T_MAX);
  localparam logic [TW-1:0] OPEN_LOAD = TW'(OPEN_CYC - 1);
  localparam logic [TW-1:0] LOCK_LOAD = TW'(LOCKOUT_CYC - 1);
  localparam logic [EW-1:0] ERR_MAX   = EW'(MAX_ERR);

  typedef enum logic [1:0] {S_LOCKED, S_OPEN, S_CHANGE, S_LOCKOUT} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [EW-1:0]   err_q, err_d, err_inc;
  logic [PW_W-1:0] pw_reg_q, pw_reg_d;
  logic [PW_W-1:0] pw_smp_q, pw_smp_d;
  logic            cmp_smp_q, cmp_smp_d, cmp_prev_q, cmp_prev_d;
  logic            set_smp_q, set_smp_d, set_prev_q, set_prev_d;
  logic            rst_smp_q, rst_smp_d;
  logic            enb_lock_q, enb_lock_d, gen_stop_q, gen_stop_d;
  logic            gen_rst_q, gen_rst_d, pw_changed_q, pw_changed_d;
  logic            cmp_rise, set_rise, timer_zero;

  // Inputs are registered once; edges are detected between consecutive samples.
  always_comb begin
    cmp_smp_d  = enb_cmp;
    cmp_prev_d = cmp_smp_q;
    set_smp_d  = set_pw;
    set_prev_d = set_smp_q;
    rst_smp_d  = rst_out;
    pw_smp_d   = pw_in;
  end

  assign cmp_rise   = cmp_smp_q & ~cmp_prev_q;
  assign set_rise   = set_smp_q & ~set_prev_q;
  assign timer_zero = (timer_q == '0);
  assign err_inc    = err_q + EW'(1);

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    err_d        = err_q;
    pw_reg_d     = pw_reg_q;
    gen_rst_d    = 1'b0;
    pw_changed_d = 1'b0;
    unique case (state_q)
      S_LOCKED: begin
        if (rst_smp_q) begin
          err_d = '0;
        end else if (cmp_rise) begin
          if (pw_smp_q == pw_reg_q) begin
            state_d = S_OPEN;
            err_d   = '0;
            timer_d = OPEN_LOAD;
          end else begin
            if (err_q != ERR_MAX) err_d = err_inc;
            if (err_inc == ERR_MAX) begin
              state_d = S_LOCKOUT;
              timer_d = LOCK_LOAD;
            end
          end
        end
      end
      S_OPEN: begin
        timer_d = timer_q - TW'(1);
        if (cmp_rise || timer_zero) begin
          state_d = S_LOCKED;
          timer_d = '0;
        end else if (set_rise) begin
          state_d = S_CHANGE;
        end
      end
      S_CHANGE: begin
        if (cmp_rise) begin
          pw_reg_d     = pw_smp_q;
          pw_changed_d = 1'b1;
          state_d      = S_LOCKED;
        end else if (set_rise || rst_smp_q) begin
          state_d = S_LOCKED;
        end
      end
      S_LOCKOUT: begin
        timer_d = timer_q - TW'(1);
        if (rst_smp_q || timer_zero) begin
          gen_rst_d = 1'b1;
          err_d     = '0;
          timer_d   = '0;
          state_d   = S_LOCKED;
        end
      end
      default: state_d = S_LOCKED;
    endcase
    enb_lock_d = (state_d == S_OPEN);
    gen_stop_d = (state_d == S_LOCKOUT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_LOCKED;
      timer_q      <= '0;
      err_q        <= '0;
      pw_reg_q     <= DEFAULT_PW;
      pw_smp_q     <= '0;
      cmp_smp_q    <= 1'b0;
      cmp_prev_q   <= 1'b0;
      set_smp_q    <= 1'b0;
      set_prev_q   <= 1'b0;
      rst_smp_q    <= 1'b0;
      enb_lock_q   <= 1'b0;
      gen_stop_q   <= 1'b0;
      gen_rst_q    <= 1'b0;
      pw_changed_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      err_q        <= err_d;
      pw_reg_q     <= pw_reg_d;
      pw_smp_q     <= pw_smp_d;
      cmp_smp_q    <= cmp_smp_d;
      cmp_prev_q   <= cmp_prev_d;
      set_smp_q    <= set_smp_d;
      set_prev_q   <= set_prev_d;
      rst_smp_q    <= rst_smp_d;
      enb_lock_q   <= enb_lock_d;
      gen_stop_q   <= gen_stop_d;
      gen_rst_q    <= gen_rst_d;
      pw_changed_q <= pw_changed_d;
    end
  end

  assign enb_lock      = enb_lock_q;
  assign gen_stop      = gen_stop_q;
  assign error_counter = err_q;
  assign gen_rst       = gen_rst_q;
  assign pw_changed    = pw_changed_q;

endmodule

// File: tb/tb_lock_ctrl_p.sv
// tb/tb_lock_ctrl_p.sv - randomized and directed checks of lock_ctrl_p against a behavioural model
module tb_lock_ctrl_p;

  localparam int MAX_ERR     = 3;
  localparam int LOCKOUT_CYC = 20;
  localparam int OPEN_CYC    = 10;
  localparam int M_LOCKED = 0, M_OPEN = 1, M_CHANGE = 2, M_LOCKOUT = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] pw_in = 16'h0000;
  logic        enb_cmp = 1'b0;
  logic        set_pw = 1'b0;
  logic        rst_out = 1'b0;
  logic        enb_lock, gen_stop, gen_rst, pw_changed;
  logic [1:0]  error_counter;

  int n_checks = 0;
  int n_errors = 0;

  lock_ctrl_p #(
    .DIGITS(4), .DEFAULT_PW(16'h0000), .MAX_ERR(MAX_ERR),
    .LOCKOUT_CYC(LOCKOUT_CYC), .OPEN_CYC(OPEN_CYC)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pw_in(pw_in), .enb_cmp(enb_cmp),
    .set_pw(set_pw), .rst_out(rst_out), .enb_lock(enb_lock),
    .gen_stop(gen_stop), .error_counter(error_counter),
    .gen_rst(gen_rst), .pw_changed(pw_changed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode plus cycles left in the current timed window.
  int          m_mode = M_LOCKED;
  int          m_left = 0;
  int          m_err  = 0;
  logic [15:0] m_pw   = 16'h0000;
  bit          m_grst = 0, m_pwc = 0;
  bit          h1_cmp = 0, h2_cmp = 0, h1_set = 0, h2_set = 0, h1_rst = 0;
  logic [15:0] h1_pw  = 16'h0000;

  always @(posedge clk or negedge reset_n) begin : model
    bit cr, sr;
    if (!reset_n) begin
      m_mode = M_LOCKED; m_left = 0; m_err = 0; m_pw = 16'h0000;
      m_grst = 0; m_pwc = 0;
      h1_cmp = 0; h2_cmp = 0; h1_set = 0; h2_set = 0; h1_rst = 0; h1_pw = 16'h0000;
    end else begin
      cr = h1_cmp && !h2_cmp;
      sr = h1_set && !h2_set;
      m_grst = 0;
      m_pwc  = 0;
      case (m_mode)
        M_LOCKED: begin
          if (h1_rst) m_err = 0;
          else if (cr) begin
            if (h1_pw == m_pw) begin
              m_mode = M_OPEN; m_err = 0; m_left = OPEN_CYC;
            end else begin
              if (m_err < MAX_ERR) m_err++;
              if (m_err == MAX_ERR) begin m_mode = M_LOCKOUT; m_left = LOCKOUT_CYC; end
            end
          end
        end
        M_OPEN: begin
          m_left--;
          if (cr || m_left == 0) m_mode = M_LOCKED;
          else if (sr) m_mode = M_CHANGE;
        end
        M_CHANGE: begin
          if (cr) begin m_pw = h1_pw; m_pwc = 1; m_mode = M_LOCKED; end
          else if (sr || h1_rst) m_mode = M_LOCKED;
        end
        default: begin
          m_left--;
          if (h1_rst || m_left == 0) begin m_grst = 1; m_err = 0; m_mode = M_LOCKED; end
        end
      endcase
      h2_cmp = h1_cmp; h1_cmp = enb_cmp;
      h2_set = h1_set; h1_set = set_pw;
      h1_rst = rst_out; h1_pw = pw_in;
    end
  end

  // Per-cycle compare against the model, plus running high-cycle counters.
  int en_cnt = 0, stop_cnt = 0, grst_cnt = 0, pwc_cnt = 0;
  always @(negedge clk) begin
    if (reset_n) begin
      chk("m_enb_lock", 32'(enb_lock), 32'(m_mode == M_OPEN));
      chk("m_gen_stop", 32'(gen_stop), 32'(m_mode == M_LOCKOUT));
      chk("m_err_cnt", 32'(error_counter), 32'(m_err));
      chk("m_gen_rst", 32'(gen_rst), 32'(m_grst));
      chk("m_pw_changed", 32'(pw_changed), 32'(m_pwc));
      en_cnt   += int'(enb_lock);
      stop_cnt += int'(gen_stop);
      grst_cnt += int'(gen_rst);
      pwc_cnt  += int'(pw_changed);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic strobe(input logic [15:0] code);
    pw_in = code; enb_cmp = 1'b1;
    tick(1);
    enb_cmp = 1'b0;
    tick(1);
  endtask

  initial begin : stim
    int b0, b1;
    logic [15:0] pick;
    tick(3);
    reset_n = 1'b1;
    chk("rst_enb_lock", 32'(enb_lock), 0);
    chk("rst_gen_stop", 32'(gen_stop), 0);
    chk("rst_err", 32'(error_counter), 0);
    chk("rst_gen_rst", 32'(gen_rst), 0);
    chk("rst_pw_changed", 32'(pw_changed), 0);

    // Correct code opens for exactly OPEN_CYC cycles.
    b0 = en_cnt;
    strobe(16'h0000);
    chk("open_now", 32'(enb_lock), 1);
    tick(12);
    chk("open_len", 32'(en_cnt - b0), 10);
    chk("open_err", 32'(error_counter), 0);
    chk("open_closed", 32'(enb_lock), 0);

    // Three failures, lockout by timeout, strobes ignored meanwhile.
    strobe(16'h1234); chk("err_1", 32'(error_counter), 1);
    strobe(16'h1234); chk("err_2", 32'(error_counter), 2);
    b0 = stop_cnt; b1 = grst_cnt;
    strobe(16'h1234);
    chk("err_3", 32'(error_counter), 3);
    chk("lockout_on", 32'(gen_stop), 1);
    repeat (3) strobe(16'h0000);
    tick(25);
    chk("lockout_len", 32'(stop_cnt - b0), 20);
    chk("gen_rst_once", 32'(grst_cnt - b1), 1);
    chk("lockout_err_clr", 32'(error_counter), 0);
    chk("lockout_no_open", 32'(enb_lock), 0);

    // Administrator clear of a lockout.
    repeat (3) strobe(16'h1234);
    tick(3);
    rst_out = 1'b1; tick(1); rst_out = 1'b0;
    chk("adm_stop_still", 32'(gen_stop), 1);
    tick(1);
    chk("adm_stop_fall", 32'(gen_stop), 0);
    chk("adm_gen_rst", 32'(gen_rst), 1);
    tick(1);
    chk("adm_gen_rst_end", 32'(gen_rst), 0);
    strobe(16'h0000);
    chk("adm_then_open", 32'(enb_lock), 1);
    tick(12);

    // Password change while open.
    strobe(16'h0000);
    set_pw = 1'b1; tick(1); set_pw = 1'b0; tick(1);
    chk("change_closed", 32'(enb_lock), 0);
    b0 = pwc_cnt;
    strobe(16'hBEEF);
    chk("pw_changed_pulse", 32'(pw_changed), 1);
    tick(1);
    chk("pw_changed_once", 32'(pwc_cnt - b0), 1);
    strobe(16'h0000);
    chk("old_pw_fails", 32'(error_counter), 1);
    strobe(16'hBEEF);
    chk("new_pw_opens", 32'(enb_lock), 1);
    tick(12);

    // Asynchronous reset mid-lockout restores the default password.
    repeat (3) strobe(16'h1234);
    chk("pre_reset_stop", 32'(gen_stop), 1);
    tick(5);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_enb_lock", 32'(enb_lock), 0);
    chk("arst_gen_stop", 32'(gen_stop), 0);
    chk("arst_err", 32'(error_counter), 0);
    chk("arst_gen_rst", 32'(gen_rst), 0);
    chk("arst_pw_changed", 32'(pw_changed), 0);
    tick(2);
    reset_n = 1'b1;
    strobe(16'h0000);
    chk("default_pw_back", 32'(enb_lock), 1);
    tick(12);

    // rst_out and compare rise together: clear wins, compare dropped.
    strobe(16'h1234);
    chk("pre_clr_err", 32'(error_counter), 1);
    pw_in = 16'h0000; enb_cmp = 1'b1; rst_out = 1'b1;
    tick(1);
    enb_cmp = 1'b0; rst_out = 1'b0;
    tick(1);
    chk("clr_err", 32'(error_counter), 0);
    tick(2);
    chk("clr_no_open", 32'(enb_lock), 0);

    // enb_cmp held high across lockout exit fires nothing.
    repeat (3) strobe(16'h1234);
    pw_in = 16'h0000; enb_cmp = 1'b1;
    b0 = en_cnt;
    tick(30);
    chk("held_no_open", 32'(en_cnt - b0), 0);
    chk("held_err", 32'(error_counter), 0);
    chk("held_unlocked", 32'(gen_stop), 0);
    enb_cmp = 1'b0;
    tick(2);

    // Randomized traffic, checked every cycle by the model.
    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 3))
        0: pick = m_pw;
        1: pick = 16'h0000;
        2: pick = 16'h1234;
        default: pick = 16'($urandom);
      endcase
      pw_in   = pick;
      enb_cmp = ($urandom_range(0, 2) == 0);
      set_pw  = ($urandom_range(0, 5) == 0);
      rst_out = ($urandom_range(0, 24) == 0);
      if (i == 700) begin
        #2 reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
      end
      tick(1);
    end
    enb_cmp = 1'b0; set_pw = 1'b0; rst_out = 1'b0;
    tick(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
